// File: rtl/bin2bcd_conv.sv
// ============================================================================
// Module   : bin2bcd_conv
// Brief    : Sequential double-dabble binary-to-BCD converter with saturation.
//            Optional leading-zero blank mask enabled by BIN2BCD_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_conv #(
  parameter int BIN_W   = 20,
  parameter int DIGITS  = 6,
  parameter int MAX_VAL = 999999
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int                 BCD_W   = 4 * DIGITS;
  localparam int                 CNT_W   = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0]   CNT_END = CNT_W'(BIN_W - 1);
  localparam logic [BIN_W-1:0]   MAX_BIN = BIN_W'(MAX_VAL);
  localparam logic [BCD_W-1:0]   SAT_BCD = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic               ovf_next_q, ovf_next_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;

  logic [BCD_W-1:0]       adj;
  logic [BCD_W+BIN_W-1:0] shifted;
  logic [BCD_W-1:0]       result;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    assign adj[4*g +: 4] = (work_q[4*g +: 4] >= 4'd5) ? (work_q[4*g +: 4] + 4'd3)
                                                      : work_q[4*g +: 4];
  end

  assign shifted = {adj, shift_q} << 1;
  assign result  = ovf_next_q ? SAT_BCD : work_q;

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic [DIGITS-1:0] blank_calc;
  logic              nz_above;

  // Walk down from the top digit; a digit is blank until a non-zero one is seen.
  always_comb begin
    blank_calc = '0;
    nz_above   = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      nz_above      = nz_above | (result[4*i +: 4] != 4'd0);
      blank_calc[i] = ~nz_above;
    end
    if (ovf_next_q) begin
      blank_calc = '0;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    work_d     = work_q;
    ovf_next_d = ovf_next_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
`ifdef BIN2BCD_BLANK_EN
    blank_d    = blank_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_SHIFT;
          cnt_d      = '0;
          shift_d    = bin;
          work_d     = '0;
          ovf_next_d = (bin > MAX_BIN);
          busy_d     = 1'b1;
        end
      end
      S_SHIFT: begin
        {work_d, shift_d} = shifted;
        if (cnt_q == CNT_END) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        bcd_d   = result;
        ovf_d   = ovf_next_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
`ifdef BIN2BCD_BLANK_EN
        blank_d = blank_calc;
`endif
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      work_q     <= '0;
      ovf_next_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
      blank_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      work_q     <= work_d;
      ovf_next_q <= ovf_next_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
`ifdef BIN2BCD_BLANK_EN
      blank_q    <= blank_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;
`ifdef BIN2BCD_BLANK_EN
  assign blank = blank_q;
`endif

endmodule

`default_nettype wire
